// File: rtl/note_sequencer.sv
// Song ROM player: fetches 16-bit words {duration, note code} and holds each note
// for duration beat ticks, with optional silent gap ticks between notes.
module note_sequencer #(
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [9:0]        note,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [9:0]          note_q, note_d;
  logic                valid_q, valid_d;
  logic [5:0]          tick_q, tick_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                done_q, done_d;
  logic                tick;

  assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      valid_q <= 1'b0;
      tick_q  <= '0;
      presc_q <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    valid_d = valid_q;
    tick_d  = tick_q;
    presc_d = presc_q;
    gap_d   = gap_q;
    done_d  = 1'b0;

    // stop overrides every transition; the ROM address is deliberately kept
    if (stop) begin
      state_d = IDLE;
      note_d  = '0;
      valid_d = 1'b0;
      tick_d  = '0;
      presc_d = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end

        FETCH: state_d = LOAD;

        LOAD: begin
          if (rom_data[15:10] == 6'd0) begin
            if (loop_en) begin
              addr_d  = '0;
              state_d = FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            note_d  = rom_data[9:0];
            valid_d = |rom_data[9:0];
            tick_d  = rom_data[15:10];
            presc_d = '0;
            state_d = PLAY;
          end
        end

        PLAY: begin
          if (tick) begin
            presc_d = '0;
            tick_d  = tick_q - 6'd1;
            if (tick_q == 6'd1) begin
              addr_d  = addr_q + ADDR_W'(1);
              note_d  = '0;
              valid_d = 1'b0;
              if (GAP_TICKS > 0) begin
                gap_d   = GAP_W'(GAP_TICKS);
                state_d = GAP;
              end else begin
                state_d = FETCH;
              end
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end

        GAP: begin
          if (tick) begin
            presc_d = '0;
            gap_d   = gap_q - GAP_W'(1);
            if (gap_q == GAP_W'(1)) begin
              state_d = FETCH;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign rom_addr   = addr_q;
  assign note       = note_q;
  assign note_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_note_sequencer;

  typedef struct packed {
    logic [9:0] note;
    logic       valid;
    logic       busy;
    logic       done;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        stop;
  logic        loopEn;
  logic [1:0]  romAddr;
  logic [15:0] romData;
  logic [9:0]  note;
  logic        noteValid;
  logic        busy;
  logic        done;

  logic [15:0] rom [0:3];
  exp_t        sbQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          sbIdx = 0;

  note_sequencer #(
    .TICK_DIV (4),
    .GAP_TICKS(1),
    .ADDR_W   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .start     (start),
    .stop      (stop),
    .loop_en   (loopEn),
    .rom_addr  (romAddr),
    .rom_data  (romData),
    .note      (note),
    .note_valid(noteValid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) romData <= rom[romAddr];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput($sformatf("sb cycle %0d {note,valid,busy,done}", sbIdx),
                    {19'b0, note, noteValid, busy, done}, {19'b0, e});
        sbIdx++;
      end
    end
  end

  task automatic pushExp(input int n, input logic [9:0] nt, input logic v,
                         input logic b, input logic d);
    for (int i = 0; i < n; i++) sbQ.push_back({nt, v, b, d});
  endtask

  task automatic pushSilence(input int n);
    pushExp(n, 10'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pushNote(input logic [9:0] nt, input int ticks);
    pushExp(ticks * 4, nt, (nt != 10'd0), 1'b1, 1'b0);
  endtask

  task automatic pushEnd();
    pushExp(1, 10'd0, 1'b0, 1'b0, 1'b1);
    pushExp(1, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic l);
    start  = s;
    stop   = p;
    loopEn = l;
  endtask

  task automatic beginSong(input logic l);
    applyStimulus(1'b1, 1'b0, l);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, l);
  endtask

  task automatic playBasic();
    beginSong(1'b0);
    pushSilence(2);
    pushNote(10'd5, 1);
    pushSilence(6);
    pushNote(10'd17, 2);
    pushSilence(6);
    pushEnd();
    waitCycles(28);
  endtask

  initial begin
    rom[0] = 16'h0405;
    rom[1] = 16'h0811;
    rom[2] = 16'h0000;
    rom[3] = 16'h0000;
    rstN   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset outputs", {19'b0, note, noteValid, busy, done}, 32'd0);
    checkOutput("reset rom_addr", 32'(romAddr), 32'd0);
    rstN = 1'b1;
    waitCycles(1);

    $display("[TB] basic play");
    playBasic();
    checkOutput("rom_addr at end marker", 32'(romAddr), 32'd2);

    $display("[TB] rest");
    rom[0] = 16'h0C00;
    beginSong(1'b0);
    pushSilence(2);
    pushNote(10'd0, 3);
    pushSilence(6);
    pushNote(10'd17, 2);
    pushSilence(6);
    pushEnd();
    waitCycles(36);
    rom[0] = 16'h0405;

    $display("[TB] loop");
    beginSong(1'b1);
    pushSilence(2);
    pushNote(10'd5, 1);
    pushSilence(6);
    pushNote(10'd17, 2);
    pushSilence(8);
    pushNote(10'd5, 1);
    waitCycles(32);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushSilence(6);
    pushNote(10'd17, 2);
    pushSilence(6);
    pushEnd();
    waitCycles(22);

    $display("[TB] stop mid-note");
    beginSong(1'b0);
    pushSilence(2);
    pushNote(10'd5, 1);
    pushSilence(6);
    pushExp(2, 10'd17, 1'b1, 1'b1, 1'b0);
    waitCycles(14);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushExp(1, 10'd17, 1'b1, 1'b1, 1'b0);
    pushExp(2, 10'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("rom_addr held on stop", 32'(romAddr), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);
    playBasic();

    $display("[TB] start and stop together in IDLE");
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushExp(3, 10'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] async reset mid-play");
    beginSong(1'b0);
    pushSilence(2);
    pushExp(2, 10'd5, 1'b1, 1'b1, 1'b0);
    waitCycles(4);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("outputs during async reset", {19'b0, note, noteValid, busy, done}, 32'd0);
    checkOutput("rom_addr during async reset", 32'(romAddr), 32'd0);
    rstN = 1'b1;
    waitCycles(1);
    pushExp(2, 10'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] address wrap");
    rom[0] = 16'h0401;
    rom[1] = 16'h0402;
    rom[2] = 16'h0403;
    rom[3] = 16'h0404;
    beginSong(1'b0);
    pushSilence(2);
    pushNote(10'd1, 1);
    pushSilence(6);
    pushNote(10'd2, 1);
    pushSilence(6);
    pushNote(10'd3, 1);
    pushSilence(6);
    pushNote(10'd4, 1);
    pushSilence(6);
    pushNote(10'd1, 1);
    waitCycles(46);
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushSilence(1);
    waitCycles(1);
    checkOutput("rom_addr after wrap", 32'(romAddr), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pushExp(1, 10'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
